// File: rtl/spart_pkg.sv
// Shared SPART arbitration types and constants.
package spart_pkg;

    localparam int unsigned SPART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND,
        HOLD
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid requester after last_grant, with wrap-around.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_valid,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    // Walk (last_grant+1 .. last_grant+N) mod N; the modulo keeps every candidate a legal index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_grant) + k) % N);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/spart_tx_arbiter.sv
// Round-robin, message-locked arbiter feeding the single SPART transmitter.
module spart_tx_arbiter
    import spart_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned HOLDOFF      = 2,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [SPART_DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      tbr,
    output logic                      tx_write,
    output logic [SPART_DATA_W-1:0]   tx_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      lock_err
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e              state_q, state_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [IW-1:0]           gidx_q, gidx_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic                    tx_write_q, tx_write_d;
    logic [SPART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                    last_q, last_d;
    logic                    lock_err_q, lock_err_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic [3:0]              ho_cnt_q, ho_cnt_d;

    logic [IW-1:0]           pick_idx;
    logic                    pick_found;
    logic                    sel_valid;
    logic                    sel_last;
    logic [SPART_DATA_W-1:0] sel_data;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    assign sel_valid = req_valid[gidx_q];
    assign sel_last  = req_last[gidx_q];
    assign sel_data  = req_data[SPART_DATA_W*gidx_q +: SPART_DATA_W];

    // Next-state and handshake logic; req_ready is the only output not taken from a flop.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        tx_write_d   = 1'b0;
        tx_data_d    = tx_data_q;
        last_d       = last_q;
        lock_err_d   = 1'b0;
        to_cnt_d     = to_cnt_q;
        ho_cnt_d     = ho_cnt_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    to_cnt_d          = '0;
                    state_d           = ARM;
                end
            end
            ARM: begin
                if (sel_valid && tbr) begin
                    req_ready[gidx_q] = 1'b1;
                    tx_data_d         = sel_data;
                    last_d            = sel_last;
                    to_cnt_d          = '0;
                    tx_write_d        = 1'b1;
                    state_d           = SEND;
                end else if (!sel_valid) begin
                    if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                        lock_err_d   = 1'b1;
                        last_grant_d = gidx_q;
                        grant_d      = '0;
                        to_cnt_d     = '0;
                        state_d      = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
            end
            SEND: begin
                ho_cnt_d = 4'(HOLDOFF);
                state_d  = HOLD;
            end
            HOLD: begin
                ho_cnt_d = ho_cnt_q - 4'd1;
                if (ho_cnt_q == 4'd1) begin
                    if (last_q) begin
                        last_grant_d = gidx_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IW'(N_REQ - 1);
            tx_write_q   <= 1'b0;
            tx_data_q    <= '0;
            last_q       <= 1'b0;
            lock_err_q   <= 1'b0;
            to_cnt_q     <= '0;
            ho_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            tx_write_q   <= tx_write_d;
            tx_data_q    <= tx_data_d;
            last_q       <= last_d;
            lock_err_q   <= lock_err_d;
            to_cnt_q     <= to_cnt_d;
            ho_cnt_q     <= ho_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;
    assign lock_err = lock_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Directed bench for spart_tx_arbiter (N_REQ=2, HOLDOFF=2, LOCK_TIMEOUT=8).
module tb_spart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tbr;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic        busy;
    logic        lock_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic bad_ready = 1'b0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         tx_cyc[$];
    logic [7:0] tx_dat[$];
    logic [1:0] tx_gnt[$];
    int         lock_cyc[$];

    spart_tx_arbiter #(
        .N_REQ        (2),
        .HOLDOFF      (2),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tbr       (tbr),
        .tx_write  (tx_write),
        .tx_data   (tx_data),
        .grant     (grant),
        .busy      (busy),
        .lock_err  (lock_err)
    );

    always #5 clk = ~clk;

    // Log strobes and lock_err pulses at the falling edge.
    always @(negedge clk) begin
        if (tx_write === 1'b1) begin
            tx_cyc.push_back(cyc);
            tx_dat.push_back(tx_data);
            tx_gnt.push_back(grant);
        end
        if (lock_err === 1'b1) lock_cyc.push_back(cyc);
    end

    task automatic drive_reqs();
        req_valid[0]   = (q0.size() != 0);
        req_valid[1]   = (q1.size() != 0);
        req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        req_last[0]    = (q0.size() != 0) ? q0[0][8] : 1'b0;
        req_last[1]    = (q1.size() != 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic tick();
        logic [1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (($countones(req_ready) > 1) || ((req_ready & ~grant) != 2'b00)) bad_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (hs[0] && q0.size() != 0) void'(q0.pop_front());
        if (hs[1] && q1.size() != 0) void'(q1.pop_front());
        drive_reqs();
    endtask

    task automatic clear_logs();
        tx_cyc.delete();
        tx_dat.delete();
        tx_gnt.delete();
        lock_cyc.delete();
        bad_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tbr = 1'b1;
        q0.delete();
        q1.delete();
        drive_reqs();
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tbr = 1'b1;
        q0.delete();
        q1.delete();
        drive_reqs();
        tick();
        tick();
        checks++; if (grant !== 2'b00)   begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL reset_tx_write: got %b expected 0", tx_write); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err: got %b expected 0", lock_err); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single_stream();
        int start;
        int drop;
        logic gbad;
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
        do_reset();
        start = cyc;
        drop = -1;
        gbad = 1'b0;
        q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h143);
        drive_reqs();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy === 1'b1 && grant !== 2'b01) gbad = 1'b1;
            if (drop < 0 && i > 0 && busy === 1'b0) drop = cyc - start;
        end
        checks++; if (tx_dat.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", tx_dat.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= tx_dat.size()) begin errors++; $display("FAIL single_byte%0d: got none expected %h", k, exp_d[k]); end
            else if (tx_dat[k] !== exp_d[k]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", k, tx_dat[k], exp_d[k]); end
        end
        if (tx_cyc.size() == 3) begin
            checks++; if (tx_cyc[0] - start != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", tx_cyc[0] - start); end
            checks++; if (tx_cyc[1] - tx_cyc[0] != 4) begin errors++; $display("FAIL single_gap1: got %0d expected 4", tx_cyc[1] - tx_cyc[0]); end
            checks++; if (tx_cyc[2] - tx_cyc[1] != 4) begin errors++; $display("FAIL single_gap2: got %0d expected 4", tx_cyc[2] - tx_cyc[1]); end
        end
        checks++; if (gbad !== 1'b0) begin errors++; $display("FAIL single_grant: got non-01 grant while busy expected 01"); end
        checks++; if (drop != 13) begin errors++; $display("FAIL single_busy_drop: got %0d expected 13", drop); end
        checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL single_ready_owner: got stray req_ready expected none"); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_d[5];
        logic [1:0] exp_g[5];
        exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12; exp_d[3] = 8'h20; exp_d[4] = 8'h21;
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b10; exp_g[4] = 2'b10;
        do_reset();
        q0.push_back(9'h010); q0.push_back(9'h011); q0.push_back(9'h112);
        q1.push_back(9'h020); q1.push_back(9'h121);
        drive_reqs();
        for (int i = 0; i < 40; i++) tick();
        checks++; if (tx_dat.size() != 5) begin errors++; $display("FAIL simul_count: got %0d expected 5", tx_dat.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= tx_dat.size()) begin errors++; $display("FAIL simul_strobe%0d: got none expected %h/%b", k, exp_d[k], exp_g[k]); end
            else if (tx_dat[k] !== exp_d[k] || tx_gnt[k] !== exp_g[k]) begin
                errors++; $display("FAIL simul_strobe%0d: got %h/%b expected %h/%b", k, tx_dat[k], tx_gnt[k], exp_d[k], exp_g[k]);
            end
        end
        checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL simul_ready_owner: got stray req_ready expected none"); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[6];
        exp_d[0] = 8'hA1; exp_d[1] = 8'hB1; exp_d[2] = 8'hA2;
        exp_d[3] = 8'hB2; exp_d[4] = 8'hA3; exp_d[5] = 8'hB3;
        do_reset();
        q0.push_back(9'h1A1); q0.push_back(9'h1A2); q0.push_back(9'h1A3);
        q1.push_back(9'h1B1); q1.push_back(9'h1B2); q1.push_back(9'h1B3);
        drive_reqs();
        for (int i = 0; i < 45; i++) tick();
        checks++; if (tx_dat.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", tx_dat.size()); end
        for (int k = 0; k < 6; k++) begin
            logic [1:0] eg;
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (k >= tx_dat.size()) begin errors++; $display("FAIL b2b_strobe%0d: got none expected %h/%b", k, exp_d[k], eg); end
            else if (tx_dat[k] !== exp_d[k] || tx_gnt[k] !== eg) begin
                errors++; $display("FAIL b2b_strobe%0d: got %h/%b expected %h/%b", k, tx_dat[k], tx_gnt[k], exp_d[k], eg);
            end
        end
        if (tx_cyc.size() >= 2) begin
            checks++; if (tx_cyc[1] - tx_cyc[0] != 5) begin errors++; $display("FAIL b2b_gap: got %0d expected 5", tx_cyc[1] - tx_cyc[0]); end
        end
    endtask

    task automatic test_tbr_stall();
        do_reset();
        tbr = 1'b0;
        q0.push_back(9'h155);
        drive_reqs();
        for (int i = 0; i < 20; i++) tick();
        checks++; if (tx_dat.size() != 0) begin errors++; $display("FAIL stall_no_write: got %0d strobes expected 0", tx_dat.size()); end
        checks++; if (lock_cyc.size() != 0) begin errors++; $display("FAIL stall_no_lock_err: got %0d pulses expected 0", lock_cyc.size()); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stall_grant: got %b expected 01", grant); end
        tbr = 1'b1;
        tick();
        checks++; if (tx_write !== 1'b1) begin errors++; $display("FAIL stall_release_write: got %b expected 1", tx_write); end
        checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL stall_release_data: got %h expected 55", tx_data); end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_lock_timeout();
        int start;
        logic [1:0] g_at_lock;
        g_at_lock = 2'bxx;
        do_reset();
        start = cyc;
        q0.push_back(9'h077);
        q1.push_back(9'h1C3);
        drive_reqs();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lock_err === 1'b1) g_at_lock = grant;
        end
        checks++; if (lock_cyc.size() != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", lock_cyc.size()); end
        if (lock_cyc.size() >= 1) begin
            checks++; if (lock_cyc[0] - start != 13) begin errors++; $display("FAIL timeout_cycle: got %0d expected 13", lock_cyc[0] - start); end
        end
        checks++; if (g_at_lock !== 2'b00) begin errors++; $display("FAIL timeout_grant_clear: got %b expected 00", g_at_lock); end
        checks++; if (tx_dat.size() != 2) begin errors++; $display("FAIL timeout_count: got %0d expected 2", tx_dat.size()); end
        if (tx_dat.size() == 2) begin
            checks++; if (tx_dat[0] !== 8'h77 || tx_gnt[0] !== 2'b01) begin errors++; $display("FAIL timeout_first: got %h/%b expected 77/01", tx_dat[0], tx_gnt[0]); end
            checks++; if (tx_dat[1] !== 8'hC3 || tx_gnt[1] !== 2'b10) begin errors++; $display("FAIL timeout_next: got %h/%b expected c3/10", tx_dat[1], tx_gnt[1]); end
            checks++; if (tx_cyc[1] - start != 15) begin errors++; $display("FAIL timeout_next_cycle: got %0d expected 15", tx_cyc[1] - start); end
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        q0.push_back(9'h031); q0.push_back(9'h032); q0.push_back(9'h133);
        drive_reqs();
        tick(); tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_in_hold: got busy=%b expected 1", busy); end
        rst = 1'b1;
        tick();
        checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL midrst_tx_write: got %b expected 0", tx_write); end
        checks++; if (grant !== 2'b00)   begin errors++; $display("FAIL midrst_grant: got %b expected 00", grant); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (tx_dat.size() != 1) begin errors++; $display("FAIL midrst_strobes: got %0d expected 1", tx_dat.size()); end
        q0.delete();
        q1.delete();
        drive_reqs();
        tick();
        rst = 1'b0;
        clear_logs();
        q0.push_back(9'h1D1);
        q1.push_back(9'h1E1);
        drive_reqs();
        for (int i = 0; i < 20; i++) tick();
        checks++; if (tx_dat.size() != 2) begin errors++; $display("FAIL midrst_after_count: got %0d expected 2", tx_dat.size()); end
        if (tx_dat.size() == 2) begin
            checks++; if (tx_dat[0] !== 8'hD1 || tx_gnt[0] !== 2'b01) begin errors++; $display("FAIL midrst_first: got %h/%b expected d1/01", tx_dat[0], tx_gnt[0]); end
            checks++; if (tx_dat[1] !== 8'hE1 || tx_gnt[1] !== 2'b10) begin errors++; $display("FAIL midrst_second: got %h/%b expected e1/10", tx_dat[1], tx_gnt[1]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        tbr       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single_stream();
        test_simultaneous();
        test_back_to_back();
        test_tbr_stall();
        test_lock_timeout();
        test_reset_mid_message();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
